elastic_pipe_reg: RTL and testbench
===================================

# elastic_pipe_reg

Parametrised, handshaked pipeline register that replaces the fixed-field, enable/flush-only inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined datapath. It carries an opaque WIDTH-bit payload with a valid/ready handshake. A two-entry skid buffer lets `in_ready` be a registered signal, so a downstream stall never forms a combinational path back to the upstream stage. Flush injects a configurable NOP payload, and a saturating counter reports downstream stall cycles for performance debug.

## Interface
- WIDTH, 32: payload width in bits; the stage wrapper packs its control and data fields into this vector.
- NOP_VALUE, '0: WIDTH-bit payload presented on `out_data` whenever the stage is empty or flushed.
- CNT_W, 16: width of the stall counter.
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage accepts a payload this cycle; registered.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  `out_data` holds a valid payload.
- out_ready  input  1  downstream consumes `out_data` this cycle.
- out_data  output  WIDTH  oldest held payload, or NOP_VALUE when empty.
- occupancy  output  2  number of held entries: 0, 1 or 2.
- stall_cnt  output  CNT_W  saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Handshake terms:
  - Input transfer = `in_valid && in_ready`.
  - Output transfer = `out_valid && out_ready`.
  - `in_valid` while `in_ready` = 0 is ignored; upstream must hold the payload.
- Storage:
  - `main` register always drives `out_data`.
  - `skid` register holds a second entry.
  - Entries leave in FIFO order.
- States and transitions (`state` is an enum):
  - EMPTY:
    - Input transfer → `main` ← `in_data`, go to ONE.
    - Otherwise stay in EMPTY.
  - ONE:
    - in + out → `main` ← `in_data`, stay in ONE.
    - in only → `skid` ← `in_data`, go to TWO.
    - out only → `main` ← NOP_VALUE, go to EMPTY.
    - Neither → hold.
  - TWO (`in_ready` = 0):
    - `out_ready` → `main` ← `skid`, go to ONE.
    - Otherwise hold.
- Output decodes:
  - `in_ready` = (state != TWO).
  - `out_valid` = (state != EMPTY).
  - `occupancy` = 0 / 1 / 2 for EMPTY / ONE / TWO.
- Flush, on the next edge:
  - state → EMPTY.
  - `main` and `skid` ← NOP_VALUE.
  - Flush overrides any simultaneous input or output transfer; the input payload is dropped. Upstream sees `in_ready` = 1 that cycle and must treat the transfer as squashed.
- Stall counter:
  - Increments by 1 on each cycle with `out_valid && !out_ready`.
  - Saturates at 2^CNT_W − 1 with no wrap.
  - Unaffected by flush; cleared only by reset.

## Timing
- Latency: a payload accepted at edge N appears on `out_data` after edge N with `out_valid` = 1, provided it enters an empty stage or the stage in ONE drains simultaneously. Otherwise it waits behind the older entry.
- Throughput: one payload per cycle while `out_ready` = 1.
- `in_ready` changes only on clock edges.
- Deasserting `out_ready` costs at most one skid entry before `in_ready` falls.
- Reset (nRST low, immediate and asynchronous):
  - state = EMPTY, `main` = `skid` = NOP_VALUE.
  - `out_valid` = 0, `in_ready` = 1, `occupancy` = 0, `stall_cnt` = 0, `out_data` = NOP_VALUE.
- Reset mid-operation discards all entries with no partial update.
- Boundary conditions:
  - In TWO, `in_valid` has no effect.
  - In EMPTY, `out_ready` has no effect and `stall_cnt` does not count.

## Structure
- Add `pipe_state_t` (EMPTY, ONE, TWO; 2-bit enum) to `cpu_types_pkg`.
- Per-stage packed payload structs (e.g. `ex_mem_t` built from `word_t`, `regbits_t`, `opcode_t`, `funct_t`) go in `cpu_types_pkg`. WIDTH is set with `$bits()` of the struct.
- Sub-module `sat_counter` (parameter CNT_W; ports CLK, nRST, inc, count) implements the stall counter.
- The stage FSM and the two registers live in `elastic_pipe_reg`.

## Test plan
- Reset: hold nRST low mid-transfer → immediately `out_valid` = 0, `in_ready` = 1, `out_data` = NOP_VALUE (0), `occupancy` = 0, `stall_cnt` = 0.
- Streaming: `out_ready` = 1, push 0x11, 0x22, 0x33 on consecutive cycles → the same values on `out_data` one cycle later each, with `occupancy` staying at 1.
- Skid fill:
  - Stimulus: push 0xA1, 0xA2 with `out_ready` = 0.
  - Response: `occupancy` = 2, `in_ready` = 0, and 0xA3 held on the input is not accepted.
  - Then raise `out_ready`: `out_data` shows 0xA1, 0xA2, 0xA3 in order.
- Flush priority: in TWO, assert `flush` together with `in_valid` (0xBB) and `out_ready` → next cycle EMPTY, `out_data` = NOP_VALUE, and 0xBB never appears.
- Stall counter: CNT_W = 4, hold a valid entry with `out_ready` = 0 for 20 cycles → `stall_cnt` reads 15, then stays 15 after a flush.
- NOP parameter: NOP_VALUE = 0xDEAD_BEEF → `out_data` = 0xDEAD_BEEF after reset and after draining to EMPTY.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipelined datapath.
//   - pipe_state_t : occupancy state of an elastic pipeline register
//   - word_t, regbits_t, opcode_t, funct_t : basic datapath fields
//   - ex_mem_t     : packed EX/MEM payload; a stage wrapper instantiates
//                    elastic_pipe_reg with WIDTH = $bits(ex_mem_t)
//   - occupancy_of : maps a pipe_state_t to its entry count
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef logic [5:0]  opcode_t;
  typedef logic [5:0]  funct_t;

  typedef struct packed {
    word_t    alu_result;
    word_t    store_data;
    regbits_t dest_reg;
    opcode_t  opcode;
    funct_t   funct;
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
  } ex_mem_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);

  function automatic logic [1:0] occupancy_of(pipe_state_t s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at its all-ones value instead of wrapping.
// Ports:
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   count : current saturating count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
// Handshaked pipeline register with a two-entry skid buffer. in_ready comes
// straight from the state flop, so a downstream stall never reaches upstream
// combinationally. Flush squashes both entries and presents NOP_VALUE.
// Ports:
//   CLK, nRST          : clock / asynchronous active-low reset
//   flush              : synchronous squash, wins over any transfer
//   in_valid/in_ready  : upstream handshake (in_ready is registered)
//   in_data            : upstream payload
//   out_valid/out_ready: downstream handshake
//   out_data           : oldest held payload, NOP_VALUE when empty
//   occupancy          : held entries, 0..2
//   stall_cnt          : saturating count of out_valid && !out_ready cycles
// -----------------------------------------------------------------------------
module elastic_pipe_reg
  import cpu_types_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;

  logic in_xfer;
  logic out_xfer;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = occupancy_of(state_q);
  assign out_data  = main_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // NOTE: every variable gets a hold default before any branch, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (out_xfer) begin
            main_d  = NOP_VALUE;
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (out_ready) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values. The two payload registers are reset too: out_data
  // must read NOP_VALUE immediately after reset, not whatever was left over.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_reg
// Scoreboard bench. The driver pushes each payload the stage should accept
// into exp_q; the monitor compares the DUT against exp_q on every falling
// edge and pops the head whenever the DUT completes an output transfer.
// The reference model is just the queue: its length is the occupancy, its
// head is out_data, and flush empties it.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_reg;

  localparam int         W       = 32;
  localparam int         CW      = 4;
  localparam logic [W-1:0] NOP   = 32'hDEAD_BEEF;
  localparam int         SAT_MAX = (1 << CW) - 1;

  logic          CLK;
  logic          nRST;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  elastic_pipe_reg #(
    .WIDTH     (W),
    .NOP_VALUE (NOP),
    .CNT_W     (CW)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           exp_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: DUT state after the last rising edge vs. the model; inputs seen
  // here are the ones that will act at the next rising edge.
  initial begin : monitor
    int sz;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1) begin
        sz = exp_q.size();
        check("occupancy", occupancy, sz);
        check("in_ready",  in_ready,  (sz < 2));
        check("out_valid", out_valid, (sz > 0));
        check("out_data",  out_data,  (sz > 0) ? exp_q[0] : NOP);
        check("stall_cnt", stall_cnt, exp_stall);
        if (out_valid && out_ready && sz > 0) void'(exp_q.pop_front());
        if (sz > 0 && !out_ready && exp_stall < SAT_MAX) exp_stall++;
      end
    end
  end

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
    int sz0;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    sz0 = exp_q.size();
    @(negedge CLK);
    #2;
    if (fl) exp_q.delete();
    else if (iv && sz0 < 2) exp_q.push_back(d);
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_now();
    nRST = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_data",  out_data,  NOP);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_stall_cnt", stall_cnt, '0);
    exp_q.delete();
    exp_stall = 0;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    nRST     = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    nRST      = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    reset_now();

    // Streaming at full rate.
    cycle(1, 32'h11, 1, 0);
    cycle(1, 32'h22, 1, 0);
    cycle(1, 32'h33, 1, 0);
    cycle(0, 32'h0,  1, 0);
    cycle(0, 32'h0,  1, 0);
    check("nop_after_drain", out_data, NOP);

    // Skid fill; 0xA3 is offered while full and must wait.
    cycle(1, 32'hA1, 0, 0);
    cycle(1, 32'hA2, 0, 0);
    cycle(1, 32'hA3, 0, 0);
    check("skid_full_occ", occupancy, 2'd2);
    check("skid_full_rdy", in_ready, 1'b0);
    cycle(1, 32'hA3, 1, 0);
    cycle(1, 32'hA3, 1, 0);
    cycle(0, 32'h0,  1, 0);
    cycle(0, 32'h0,  1, 0);

    // Flush in TWO with simultaneous in and out transfers.
    cycle(1, 32'hC1, 0, 0);
    cycle(1, 32'hC2, 0, 0);
    cycle(1, 32'hBB, 1, 1);
    check("flush_occ",  occupancy, 2'd0);
    check("flush_data", out_data,  NOP);
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 1, 0);

    // Stall counter saturation, then flush leaves it untouched.
    cycle(1, 32'hE1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 32'h0, 0, 0);
    check("stall_sat", stall_cnt, SAT_MAX);
    cycle(0, 32'h0, 0, 1);
    cycle(0, 32'h0, 1, 0);
    check("stall_after_flush", stall_cnt, SAT_MAX);

    // Reset while two entries are held and a transfer is offered.
    cycle(1, 32'hF1, 0, 0);
    cycle(1, 32'hF2, 0, 0);
    in_valid  = 1'b1;
    in_data   = 32'hF3;
    out_ready = 1'b1;
    reset_now();
    cycle(0, 32'h0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
    end

    // Drain to empty.
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 0);
    check("final_nop", out_data, NOP);
    check("final_occ", occupancy, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
